// File: rtl/pwm_capture.sv
// pwm_capture: single-channel PWM decoder that measures active time and period in clock cycles.
// Define PWM_CAPTURE_FILTER_EN to insert a 3-sample majority glitch filter after the synchronizer.
module pwm_capture #(
    parameter int WIDTH      = 17,
    parameter int TIMEOUT    = 100000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] high_time,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             stuck,
    output logic             stuck_level
);
    localparam logic [WIDTH-1:0] TIMEOUT_V  = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] TIMEOUT_M1 = WIDTH'(TIMEOUT - 1);

    logic             sync1;
    logic             sync2;
    logic             s;
    logic             s_d;
    logic             rise;
    logic             timeout;
    logic             armed;
    logic [WIDTH-1:0] period_cnt;
    logic [WIDTH-1:0] high_cnt;

    // Normalising ahead of the first flop is a constant inversion (no glitch path),
    // so a cleared synchronizer reads as "inactive" and cannot fake a rise at reset release.
    // NOTE: every flop uses non-blocking (<=) so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwm_in ^ ACTIVE_LOW;
            sync2 <= sync1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic hist1;
    logic hist2;

    always_ff @(posedge clock) begin
        if (reset) begin
            hist1 <= 1'b0;
            hist2 <= 1'b0;
            s     <= 1'b0;
        end else begin
            hist1 <= sync2;
            hist2 <= hist1;
            s     <= (sync2 & hist1) | (sync2 & hist2) | (hist1 & hist2);
        end
    end
`else
    assign s = sync2;
`endif

    assign rise    = s & ~s_d;
    assign timeout = (period_cnt == TIMEOUT_M1) & ~rise & ~stuck;

    always_ff @(posedge clock) begin
        if (reset) begin
            s_d         <= 1'b0;
            period_cnt  <= '0;
            high_cnt    <= '0;
            high_time   <= '0;
            period      <= '0;
            valid       <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
            armed       <= 1'b0;
        end else begin
            s_d   <= s;
            valid <= 1'b0;
            if (rise) begin
                // The rise sample opens the new period; the latched values cover only the old one.
                period_cnt <= WIDTH'(1);
                high_cnt   <= WIDTH'(1);
                if (armed) begin
                    high_time <= high_cnt;
                    period    <= period_cnt;
                    valid     <= 1'b1;
                end
                armed <= 1'b1;
                stuck <= 1'b0;
            end else begin
                if (period_cnt != TIMEOUT_V) begin
                    period_cnt <= period_cnt + 1'b1;
                end
                if (s && (high_cnt != TIMEOUT_V)) begin
                    high_cnt <= high_cnt + 1'b1;
                end
                if (timeout) begin
                    period      <= TIMEOUT_V;
                    high_time   <= s ? TIMEOUT_V : '0;
                    stuck       <= 1'b1;
                    stuck_level <= s;
                    valid       <= 1'b1;
                    armed       <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and random pin waveforms checked against a rise-list model of pwm_capture.
// The model adapts its pin-to-decision latency when PWM_CAPTURE_FILTER_EN is defined.
module tb_pwm_capture;
    localparam int T  = 1000;
    localparam bit AL = 1'b1;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int LAT = FILT ? 4 : 2;

    typedef struct {
        int edge_no;
        int ht;
        int per;
        int stk;
        int lvl;
    } ev_t;

    logic        clock;
    logic        reset;
    logic        pwm_in;
    logic [16:0] high_time;
    logic [16:0] period;
    logic        valid;
    logic        stuck;
    logic        stuck_level;

    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;
    ev_t  obs[$];
    bit   nq[$];

    pwm_capture #(.WIDTH(17), .TIMEOUT(T), .ACTIVE_LOW(AL)) dut (
        .clock      (clock),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .high_time  (high_time),
        .period     (period),
        .valid      (valid),
        .stuck      (stuck),
        .stuck_level(stuck_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edge index since reset release; every valid is logged with the edge that produced it.
    always @(posedge clock) edge_cnt <= reset ? 0 : edge_cnt + 1;

    always @(negedge clock) begin
        if (edge_cnt == 0) obs.delete();
        else if (valid) obs.push_back('{edge_cnt, int'(high_time), int'(period), int'(stuck), int'(stuck_level)});
    end

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Expected events from the active/inactive sample list: find the rises after the
    // front-end latency, then apply the period, timeout and arming rules between them.
    function automatic void run_model(input bit n[$], output ev_t e[$]);
        int last;
        int start;
        int d;
        int hsum;
        bit armed;
        bit lvl;
        bit nd[];
        bit x[];
        int rises[$];
        last = n.size();
        nd = new[last + 1];
        x  = new[last + 1];
        nd[0] = 1'b0;
        for (int k = 1; k <= last; k++) nd[k] = n[k-1];
        for (int j = 0; j <= last; j++) begin
            bit a;
            bit b;
            bit c;
            a = (j >= 3) ? nd[j-3] : 1'b0;
            b = (j >= 4) ? nd[j-4] : 1'b0;
            c = (j >= 5) ? nd[j-5] : 1'b0;
            x[j] = FILT ? ((a & b) | (a & c) | (b & c)) : ((j >= 2) ? nd[j-2] : 1'b0);
        end
        for (int j = 1; j <= last; j++) if (x[j] && !x[j-1]) rises.push_back(j);
        e.delete();
        start = 1;
        armed = 1'b0;
        lvl   = 1'b0;
        foreach (rises[i]) begin
            d = start + T - 1;
            if (rises[i] > d) begin
                lvl = x[d];
                e.push_back('{d, x[d] ? T : 0, T, 1, int'(lvl)});
            end else if (armed) begin
                hsum = 0;
                for (int j = start; j < rises[i]; j++) hsum += int'(x[j]);
                e.push_back('{rises[i], hsum, rises[i] - start, 0, int'(lvl)});
            end
            start = rises[i];
            armed = 1'b1;
        end
        d = start + T - 1;
        if (d <= last) e.push_back('{d, x[d] ? T : 0, T, 1, int'(x[d])});
    endfunction

    task automatic drive(input bit act, input int len);
        for (int i = 0; i < len; i++) begin
            pwm_in = act ^ AL;
            nq.push_back(act);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clock);
        #1;
        check("rst high_time", int'(high_time), 0);
        check("rst period", int'(period), 0);
        check("rst valid", int'(valid), 0);
        check("rst stuck", int'(stuck), 0);
        check("rst stuck_level", int'(stuck_level), 0);
        reset = 1'b0;
        nq.delete();
    endtask

    task automatic compare(input string name);
        ev_t e[$];
        @(negedge clock);
        #1;
        run_model(nq, e);
        check({name, " count"}, obs.size(), e.size());
        for (int i = 0; i < e.size() && i < obs.size(); i++) begin
            check($sformatf("%s ev%0d edge", name, i), obs[i].edge_no, e[i].edge_no);
            check($sformatf("%s ev%0d high_time", name, i), obs[i].ht, e[i].ht);
            check($sformatf("%s ev%0d period", name, i), obs[i].per, e[i].per);
            check($sformatf("%s ev%0d stuck", name, i), obs[i].stk, e[i].stk);
            check($sformatf("%s ev%0d stuck_level", name, i), obs[i].lvl, e[i].lvl);
            check($sformatf("%s ev%0d high<=period", name, i), int'(obs[i].ht <= obs[i].per), 1);
        end
    endtask

    function automatic int field(input int idx, input int which);
        if (idx >= obs.size()) return -1;
        case (which)
            0:       return obs[idx].edge_no;
            1:       return obs[idx].ht;
            2:       return obs[idx].per;
            3:       return obs[idx].stk;
            default: return obs[idx].lvl;
        endcase
    endfunction

    initial begin
        reset  = 1'b1;
        pwm_in = AL;
        repeat (2) @(posedge clock);
        #1;

        // 25/100 waveform: first rise only arms, then one result per period.
        apply_reset(1);
        repeat (4) begin
            drive(1'b1, 25);
            drive(1'b0, 75);
        end
        drive(1'b0, 20);
        compare("duty25");
        check("duty25 count", obs.size(), 3);
        check("duty25 first edge", field(0, 0), 101 + LAT);
        check("duty25 high_time", field(0, 1), 25);
        check("duty25 period", field(0, 2), 100);
        check("duty25 spacing", field(1, 0) - field(0, 0), 100);

        // Line held inactive: one stuck result at TIMEOUT, then silence.
        pwm_in = AL;
        apply_reset(1);
        drive(1'b0, 4000);
        compare("idle");
        check("idle count", obs.size(), 1);
        check("idle edge", field(0, 0), T);
        check("idle high_time", field(0, 1), 0);
        check("idle period", field(0, 2), T);
        check("idle stuck", field(0, 3), 1);
        check("idle stuck_level", field(0, 4), 0);
        check("idle stuck held", int'(stuck), 1);

        // Line held active, then a 40/100 waveform clears stuck without a result.
        pwm_in = 1'b1 ^ AL;
        apply_reset(1);
        drive(1'b1, 1100);
        drive(1'b0, 60);
        repeat (3) begin
            drive(1'b1, 40);
            drive(1'b0, 60);
        end
        drive(1'b0, 10);
        compare("held");
        check("held count", obs.size(), 3);
        check("held high_time", field(0, 1), T);
        check("held period", field(0, 2), T);
        check("held stuck_level", field(0, 4), 1);
        check("held next high_time", field(1, 1), 40);
        check("held next period", field(1, 2), 100);
        check("held stuck cleared", int'(stuck), 0);

        // Reset pulse in the inactive phase of a 30/100 waveform.
        pwm_in = AL;
        apply_reset(1);
        repeat (2) begin
            drive(1'b1, 30);
            drive(1'b0, 70);
        end
        drive(1'b1, 30);
        drive(1'b0, 30);
        compare("midrst_pre");
        apply_reset(1);
        drive(1'b0, 40);
        repeat (3) begin
            drive(1'b1, 30);
            drive(1'b0, 70);
        end
        drive(1'b0, 10);
        compare("midrst");
        check("midrst count", obs.size(), 2);
        check("midrst high_time", field(0, 1), 30);
        check("midrst period", field(0, 2), 100);

        // Rise landing exactly on the timeout edge wins over the timeout.
        apply_reset(1);
        drive(1'b0, T - 1 - LAT);
        drive(1'b1, 20);
        drive(1'b0, 80);
        drive(1'b1, 20);
        drive(1'b0, 10);
        compare("edge_rise");
        check("edge_rise count", obs.size(), 1);
        check("edge_rise period", field(0, 2), 100);
        check("edge_rise stuck", int'(stuck), 0);

        // 20/100 with a one-cycle inactive glitch inside the active phase.
        apply_reset(1);
        repeat (3) begin
            drive(1'b1, 10);
            drive(1'b0, 1);
            drive(1'b1, 9);
            drive(1'b0, 80);
        end
        drive(1'b0, 10);
        compare("glitch");
        check("glitch high_time", field(0, 1), FILT ? 20 : 10);
        check("glitch period", field(0, 2), FILT ? 100 : 11);

        // Random pulse trains, including single-cycle pulses and both stuck levels.
        apply_reset(1);
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, (i == 9) ? 1050 : int'($urandom_range(1, 90)));
            drive(1'b0, (i == 5) ? 1200 : int'($urandom_range(1, 90)));
        end
        drive(1'b0, 10);
        compare("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
